// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Memory-stage controller sitting between the E/M and M/W pipeline
//   registers. Non-memory instructions pass straight through. Loads and
//   stores are issued on a req/ack data-memory port with variable latency.
//   While an access is outstanding the unit raises StallM and sends a bubble
//   (PCSrcM/RegWriteM/MemToRegM forced low) toward M/W. On completion it
//   presents the result to M/W for one full cycle (state DONE).
//
//   Optional feature (macro MEM_TIMEOUT_EN): a BUSY cycle counter forces
//   completion after TIMEOUT cycles without mem_ack. In that case MemErrM is
//   raised, ReadDataM reads 0 and RegWriteM is suppressed for the DONE cycle.
//   Without the macro, BUSY waits indefinitely and MemErrM is tied low.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   *E2M                instruction fields from the E/M register (held
//                       stable by upstream while StallM=1)
//   mem_rdata, mem_ack  memory read data and one-cycle completion strobe
//   mem_req, mem_we,    registered memory request, write enable,
//   mem_addr, mem_wdata address and store data
//   StallM              freeze request to the hazard unit
//   *M                  fields toward the M/W register
//   MemErrM             access was ended by the timeout
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PCSrcE2M,
    input  logic            RegWriteE2M,
    input  logic            MemToRegE2M,
    input  logic            MemWriteE2M,
    input  logic [4:0]      WA3E2M,
    input  logic [SIZE-1:0] ALUOutE2M,
    input  logic [SIZE-1:0] WriteDataE2M,
    input  logic [SIZE-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_wdata,
    output logic            StallM,
    output logic            PCSrcM,
    output logic            RegWriteM,
    output logic            MemToRegM,
    output logic [4:0]      WA3M,
    output logic [SIZE-1:0] ALUOutM,
    output logic [SIZE-1:0] ReadDataM,
    output logic            MemErrM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [SIZE-1:0]   mem_addr_q,  mem_addr_d;
    logic [SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SIZE-1:0]   rdata_q,     rdata_d;
    logic              err_q,       err_d;
    logic              acc_s;
    logic              stall_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter value seen during the TIMEOUT-th BUSY cycle (counter starts at 0).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    assign acc_s   = MemToRegE2M | MemWriteE2M;
    // Stall while waiting to issue (IDLE with an access) and while outstanding.
    assign stall_s = (state_q == BUSY) | ((state_q == IDLE) & acc_s);

    // Next-state and next-register computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (acc_s) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWriteE2M;
                    mem_addr_d  = ALUOutE2M;
                    mem_wdata_d = WriteDataE2M;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    // Ack wins over a coinciding timeout.
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                else begin
                    state_d = BUSY;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                err_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Outputs toward M/W: bubble during stall, suppress writeback on error.
    always_comb begin
        if (stall_s) begin
            PCSrcM    = 1'b0;
            RegWriteM = 1'b0;
            MemToRegM = 1'b0;
        end else begin
            PCSrcM    = PCSrcE2M;
            RegWriteM = RegWriteE2M & ~err_q;
            MemToRegM = MemToRegE2M;
        end
    end

    assign StallM    = stall_s;
    assign WA3M      = WA3E2M;
    assign ALUOutM   = ALUOutE2M;
    assign ReadDataM = rdata_q;
    assign MemErrM   = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q & mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Self-checking bench for mem_access_unit: a vector table for the
//   pass-through path, hand-written access sequences (load, store,
//   back-to-back, reset mid-access, optional timeout) and randomized
//   instructions checked against a transaction-level model of ReadDataM.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int SIZE = 32;
    localparam int TO   = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic            PCSrcE2M, RegWriteE2M, MemToRegE2M, MemWriteE2M;
    logic [4:0]      WA3E2M;
    logic [SIZE-1:0] ALUOutE2M, WriteDataE2M, mem_rdata;
    logic            mem_ack;
    logic            mem_req, mem_we;
    logic [SIZE-1:0] mem_addr, mem_wdata;
    logic            StallM, PCSrcM, RegWriteM, MemToRegM;
    logic [4:0]      WA3M;
    logic [SIZE-1:0] ALUOutM, ReadDataM;
    logic            MemErrM;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_model;   // value ReadDataM must hold

    mem_access_unit #(.SIZE(SIZE), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .PCSrcE2M(PCSrcE2M), .RegWriteE2M(RegWriteE2M),
        .MemToRegE2M(MemToRegE2M), .MemWriteE2M(MemWriteE2M),
        .WA3E2M(WA3E2M), .ALUOutE2M(ALUOutE2M), .WriteDataE2M(WriteDataE2M),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .StallM(StallM),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
        .WA3M(WA3M), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .MemErrM(MemErrM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        pc;
        logic        rw;
        logic [4:0]  wa3;
        logic [31:0] alu;
        logic        exp_pc;
        logic        exp_rw;
        logic [4:0]  exp_wa3;
        logic [31:0] exp_alu;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_nonmem(input logic pc, input logic rw, input logic [4:0] wa3,
                                input logic [31:0] alu);
        PCSrcE2M = pc; RegWriteE2M = rw; MemToRegE2M = 1'b0; MemWriteE2M = 1'b0;
        WA3E2M = wa3; ALUOutE2M = alu; WriteDataE2M = $urandom;
    endtask

    // One non-memory instruction: one cycle, no stall, pass-through.
    task automatic do_nonmem(input logic pc, input logic rw, input logic [4:0] wa3,
                             input logic [31:0] alu);
        drive_nonmem(pc, rw, wa3, alu);
        mem_ack = 1'b0;
        #4;
        chk("nm_stall", StallM, 0);
        chk("nm_req", mem_req, 0);
        chk("nm_pc", PCSrcM, pc);
        chk("nm_rw", RegWriteM, rw);
        chk("nm_m2r", MemToRegM, 0);
        chk("nm_wa3", WA3M, wa3);
        chk("nm_alu", ALUOutM, alu);
        chk("nm_rdata", ReadDataM, rd_model);
        next_cycle();
    endtask

    // One load/store: IDLE stall cycle, k BUSY cycles (ack in the k-th) or a
    // timeout after TO BUSY cycles, then a DONE cycle.
    task automatic do_access(input bit st, input logic pc, input logic rw,
                             input logic [4:0] wa3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int k, input bit tmo);
        int n_busy;
        PCSrcE2M = pc; RegWriteE2M = rw; MemToRegE2M = !st; MemWriteE2M = st;
        WA3E2M = wa3; ALUOutE2M = addr; WriteDataE2M = wdata; mem_ack = 1'b0;
        #4;
        chk("idle_stall", StallM, 1);
        chk("idle_req", mem_req, 0);
        chk("idle_bub_rw", RegWriteM, 0);
        chk("idle_bub_pc", PCSrcM, 0);
        chk("idle_bub_m2r", MemToRegM, 0);
        next_cycle();
        n_busy = tmo ? TO : k;
        for (int i = 1; i <= n_busy; i++) begin
            mem_ack   = (!tmo && i == k);
            mem_rdata = (i == k) ? rdata : $urandom;
            #4;
            chk("busy_stall", StallM, 1);
            chk("busy_req", mem_req, 1);
            chk("busy_we", mem_we, st);
            chk("busy_addr", mem_addr, addr);
            if (st) chk("busy_wdata", mem_wdata, wdata);
            chk("busy_bub_rw", RegWriteM, 0);
            chk("busy_bub_m2r", MemToRegM, 0);
            next_cycle();
        end
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (tmo) rd_model = 32'h0;
        else if (!st) rd_model = rdata;
        #4;
        chk("done_stall", StallM, 0);
        chk("done_req", mem_req, 0);
        chk("done_we", mem_we, 0);
        chk("done_rdata", ReadDataM, rd_model);
        chk("done_err", MemErrM, tmo);
        chk("done_rw", RegWriteM, tmo ? 1'b0 : rw);
        chk("done_m2r", MemToRegM, !st);
        chk("done_pc", PCSrcM, pc);
        chk("done_alu", ALUOutM, addr);
        chk("done_wa3", WA3M, wa3);
        next_cycle();
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd3,  32'h0000_0010, 1'b0, 1'b1, 5'd3,  32'h0000_0010};
        vecs[1] = '{1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 1'b1, 5'd0,  32'h0000_0000, 1'b1, 1'b1, 5'd0,  32'h0000_0000};
        vecs[3] = '{1'b0, 1'b0, 5'd17, 32'hA5A5_5A5A, 1'b0, 1'b0, 5'd17, 32'hA5A5_5A5A};

        RST = 1'b1;
        drive_nonmem(1'b0, 1'b0, 5'd0, 32'h0);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        rd_model = 32'h0;
        next_cycle();
        next_cycle();
        #4;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_err", MemErrM, 0);
        chk("rst_stall", StallM, 0);
        next_cycle();
        RST = 1'b0;

        // Pass-through vector table.
        for (int v = 0; v < 4; v++) begin
            drive_nonmem(vecs[v].pc, vecs[v].rw, vecs[v].wa3, vecs[v].alu);
            #4;
            chk("tbl_stall", StallM, 0);
            chk("tbl_req", mem_req, 0);
            chk("tbl_pc", PCSrcM, vecs[v].exp_pc);
            chk("tbl_rw", RegWriteM, vecs[v].exp_rw);
            chk("tbl_wa3", WA3M, vecs[v].exp_wa3);
            chk("tbl_alu", ALUOutM, vecs[v].exp_alu);
            next_cycle();
        end

        // Load, ack after 2 BUSY cycles.
        do_access(1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
        // Store, ack after 1 cycle; ReadDataM must stay 0xDEADBEEF.
        do_access(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0080, 32'h1234_5678, 32'h0BAD_0BAD, 1, 1'b0);
        chk("store_keeps_rdata", ReadDataM, 32'hDEAD_BEEF);
        // Back-to-back loads.
        do_access(1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0100, 32'h0, 32'h1111_1111, 1, 1'b0);
        do_access(1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0104, 32'h0, 32'h2222_2222, 3, 1'b0);

        // Reset while BUSY, then a late ack that must be ignored.
        PCSrcE2M = 1'b0; RegWriteE2M = 1'b1; MemToRegE2M = 1'b1; MemWriteE2M = 1'b0;
        WA3E2M = 5'd9; ALUOutE2M = 32'h0000_0200; mem_ack = 1'b0;
        next_cycle();
        #4;
        chk("rb_busy_req", mem_req, 1);
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        rd_model = 32'h0;
        drive_nonmem(1'b0, 1'b0, 5'd0, 32'h0);
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        #4;
        chk("rb_req", mem_req, 0);
        chk("rb_stall", StallM, 0);
        chk("rb_rdata", ReadDataM, 0);
        next_cycle();
        mem_ack = 1'b0;
        #4;
        chk("rb_req2", mem_req, 0);
        chk("rb_rdata2", ReadDataM, 0);
        chk("rb_stall2", StallM, 0);
        next_cycle();

`ifdef MEM_TIMEOUT_EN
        do_access(1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0300, 32'h0, 32'h0, 0, 1'b1);
        do_access(1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0304, 32'h0, 32'h4444_4444, TO, 1'b0);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0)
                do_nonmem(1'($urandom), 1'($urandom), 5'($urandom), $urandom);
            else
                do_access(kind == 2, 1'($urandom), 1'($urandom), 5'($urandom),
                          $urandom, $urandom, $urandom, $urandom_range(1, TO), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
